ind_led: RTL and testbench
==========================

// Module: ind_led
// PURPOSE
//  Bus-mapped two-LED status indicator. A CPU-side bus writes command codes via addr
//  qualified by cs/wr (no data bus). Each LED is set to OFF, ON or BLINK.
//  Sits as a small peripheral on the system bus and drives board LEDs directly.
// PARAMETERS
//  BLINK_HALF  25_000_000  clk cycles per blink half-period; must be >=1.
//  CNT_W       26          blink counter width; must satisfy 2^CNT_W > BLINK_HALF.
//  LED_POL     1           1: LED lit = output 1; 0: outputs inverted (active-low LEDs).
// PORTS
//  clk   in  1  system clock; all logic on its rising edge
//  rst   in  1  synchronous, active-low reset
//  addr  in  4  command code (decoded when a write strobe is valid)
//  cs    in  1  chip select
//  rd    in  1  read strobe; no readable state, so ignored except to block writes
//  wr    in  1  write strobe
//  led1  out 1  LED 1 drive
//  led2  out 1  LED 2 drive
// BEHAVIOUR
//  - Write strobe = cs & wr & ~rd. Sampled every rising edge. Level-sensitive.
//  - Holding the strobe re-executes the command each cycle; this is harmless.
//  - cs=0, or wr=0, or rd=1 -> no command executes and state is held.
//  - Per-LED mode register mode1/mode2 takes values OFF, ON or BLINK.
//  - Command decode (addr):
//      0x0 both OFF          0x1 led1 ON      0x2 led1 BLINK    0x3 led1 OFF
//      0x4 led2 ON           0x5 led2 BLINK   0x6 led2 OFF
//      0x8 both ON           0x9 both BLINK   others: no effect
//  - Blink engine: a free-running counter counts 0..BLINK_HALF-1 and wraps to 0.
//    On the wrap, phase toggles. Phase is shared, so BLINK LEDs are always in step.
//    The counter is not restarted by commands.
//  - Lit level per LED: OFF->0, ON->1, BLINK->phase. Output = lit ^ ~LED_POL.
//  - Outputs are registered and computed from the next-state mode and phase.
//    A command sampled at edge N takes effect on the outputs at edge N (1-cycle latency from strobe).
//  - Reset (rst==0 at an edge): mode1=mode2=OFF, counter=0, phase=0.
//    led1=led2=~LED_POL, i.e. LEDs dark.
//  - Reset wins over a simultaneous write. Reset mid-blink clears the phase.
//  - After reset, a BLINK LED is lit first once BLINK_HALF cycles have elapsed since reset release.
// TESTING
//  1. Hold rst=0 for 5 cycles, strobes idle -> led1=led2=0 (LED_POL=1) during and after reset.
//  2. BLINK_HALF=8. Write 0x0, then 0x2 held -> led2=0 steady.
//     led1 toggles every 8 cycles, with phase aligned to the free-running counter.
//  3. Write 0x8 -> led1=led2=1 at the sampling edge. Then write 0x4 -> both remain 1.
//     Then write 0x6 -> led2=0, led1=1.
//  4. Write 0x9 -> both LEDs toggle in the same cycle every 8 cycles.
//     Then write 0x0 -> both 0 on the next edge.
//  5. addr=0x1 with cs=0, or with wr=0, or with rd=1 -> outputs unchanged.
//     Undefined codes 0x7, 0xA-0xF with a valid strobe -> outputs unchanged.
//  6. Assert rst while in BLINK -> both 0 and modes OFF. After release, write 0x2 -> led1 stays 0
//     until 8 cycles after release, then goes 1. Repeat the whole suite with LED_POL=0 -> all outputs inverted.

Source files
------------

// File: rtl/ind_led_if.sv
// Command bus into the LED indicator: a 4-bit command code qualified by cs/wr,
// with rd present only so that a read cycle can block a write.
interface ind_led_if;
  logic [3:0] addr;
  logic       cs;
  logic       rd;
  logic       wr;

  modport master (output addr, cs, rd, wr);
  modport slave  (input  addr, cs, rd, wr);
endinterface

// File: rtl/ind_led.sv
// Two-LED status indicator: bus command codes set each LED to OFF, ON or BLINK;
// both blinking LEDs share one free-running half-period counter and phase.
module ind_led #(
  parameter int BLINK_HALF = 25_000_000,
  parameter int CNT_W      = 26,
  parameter bit LED_POL    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  ind_led_if.slave   bus,
  output logic       led1,
  output logic       led2
);
  typedef enum logic [1:0] {OFF = 2'd0, ON = 2'd1, BLINK = 2'd2} mode_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_HALF - 1);

  mode_e            mode     [2];
  mode_e            mode_nxt [2];
  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             phase_nxt;
  logic             wrap;
  logic             strobe;
  logic [1:0]       lit;
  logic [1:0]       led_q;

  assign strobe    = bus.cs & bus.wr & ~bus.rd;
  assign wrap      = (cnt == LAST);
  assign phase_nxt = phase ^ wrap;

  // Index 0 is led1, index 1 is led2.
  always_comb begin
    mode_nxt[0] = mode[0];
    mode_nxt[1] = mode[1];
    if (strobe) begin
      case (bus.addr)
        4'h0: begin mode_nxt[0] = OFF;   mode_nxt[1] = OFF;   end
        4'h1: mode_nxt[0] = ON;
        4'h2: mode_nxt[0] = BLINK;
        4'h3: mode_nxt[0] = OFF;
        4'h4: mode_nxt[1] = ON;
        4'h5: mode_nxt[1] = BLINK;
        4'h6: mode_nxt[1] = OFF;
        4'h8: begin mode_nxt[0] = ON;    mode_nxt[1] = ON;    end
        4'h9: begin mode_nxt[0] = BLINK; mode_nxt[1] = BLINK; end
        default: ;
      endcase
    end
  end

  // Outputs are built from next-state mode and phase so a command shows up
  // on the same edge that samples it.
  generate
    for (genvar i = 0; i < 2; i++) begin : g_lit
      assign lit[i] = (mode_nxt[i] == ON) | ((mode_nxt[i] == BLINK) & phase_nxt);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode[0] <= OFF;
      mode[1] <= OFF;
      cnt     <= '0;
      phase   <= 1'b0;
      led_q   <= {2{~LED_POL}};
    end else begin
      mode[0] <= mode_nxt[0];
      mode[1] <= mode_nxt[1];
      cnt     <= wrap ? '0 : cnt + 1'b1;
      phase   <= phase_nxt;
      led_q   <= lit ^ {2{~LED_POL}};
    end
  end

  assign led1 = led_q[0];
  assign led2 = led_q[1];
endmodule

// File: tb/tb_ind_led.sv
// Bench for ind_led: one active-high and one active-low instance share the bus;
// a vector table feeds a scoreboard whose blink phase comes from cycles since reset.
module tb_ind_led;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  logic a1, a2, b1, b2;

  ind_led_if bus ();

  ind_led #(.BLINK_HALF(HALF), .CNT_W(4), .LED_POL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus), .led1(a1), .led2(a2));
  ind_led #(.BLINK_HALF(HALF), .CNT_W(4), .LED_POL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus), .led1(b1), .led2(b2));

  always #5 clk = ~clk;

  // Expected lit code per LED: 0 dark, 1 lit, 2 follows the blink phase.
  typedef struct {
    logic       rst, cs, wr, rd;
    logic [3:0] addr;
    int         e1, e2;
  } vec_t;

  typedef struct {
    logic l1, l2;
    int   idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   t = 0;

  task automatic add(input logic r, input logic c, input logic w, input logic rd_i,
                     input logic [3:0] a, input int e1, input int e2, input int n = 1);
    vec_t v;
    v.rst = r; v.cs = c; v.wr = w; v.rd = rd_i; v.addr = a; v.e1 = e1; v.e2 = e2;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic cmd(input logic [3:0] a, input int e1, input int e2, input int n = 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, a, e1, e2, n);
  endtask

  task automatic idle(input int e1, input int e2, input int n = 1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, e1, e2, n);
  endtask

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got led1,led2=%b required %b", name, got, want);
  endtask

  function automatic logic lvl(input int code, input logic ph);
    return (code == 2) ? ph : (code == 1);
  endfunction

  initial begin
    exp_t e;
    logic ph;
    int   n;
    rst = 1'b0; bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = 4'h0;

    // Reset, with a write strobe present during it that must lose.
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 3);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'h8, 0, 0, 2);
    idle(0, 0, 2);
    cmd(4'h0, 0, 0);
    cmd(4'h2, 2, 0, 20);                 // held: led1 blinks, led2 dark
    cmd(4'h8, 1, 1);
    cmd(4'h4, 1, 1);
    cmd(4'h6, 1, 0);
    idle(1, 0, 2);
    cmd(4'h9, 2, 2, 12);
    idle(2, 2, 6);
    cmd(4'h0, 0, 0);
    // Gated commands from the all-off state.
    add(1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 0, 0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 0, 0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 0, 0);
    cmd(4'h1, 1, 0);
    cmd(4'h5, 1, 2, 3);
    cmd(4'h3, 0, 2);
    cmd(4'h8, 1, 1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1, 1);
    add(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1, 1);
    cmd(4'h7, 1, 1);
    for (int c = 10; c < 16; c++) cmd(4'(c), 1, 1);
    cmd(4'h0, 0, 0);
    cmd(4'hF, 0, 0);
    // Reset mid-blink, then led1 blink restarts with phase cleared.
    cmd(4'h9, 2, 2, 11);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 2);
    cmd(4'h2, 2, 0);
    idle(2, 0, 18);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; bus.cs = vecs[i].cs; bus.wr = vecs[i].wr;
      bus.rd = vecs[i].rd; bus.addr = vecs[i].addr;
      t  = vecs[i].rst ? t + 1 : 0;
      ph = ((t / HALF) % 2) == 1;
      e.l1 = lvl(vecs[i].e1, ph); e.l2 = lvl(vecs[i].e2, ph); e.idx = i;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      check($sformatf("vec%0d_pol1", e.idx), {a1, a2}, {e.l1, e.l2});
      check($sformatf("vec%0d_pol0", e.idx), {b1, b2}, ~{e.l1, e.l2});
    end

    // First lit edge of a blink after reset release, bounded wait.
    rst = 1'b0; bus.cs = 1'b0; bus.wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = 4'h2;
    n = 0;
    while (n < 30) begin
      @(posedge clk); #1;
      n++;
      bus.cs = 1'b0; bus.wr = 1'b0;
      if (a1) break;
    end
    checks++;
    if (n == HALF) passed++;
    else $display("FAIL first_lit_edge: got %0d cycles required %0d", n, HALF);
    check("first_lit_pol0", {b1, b2}, 2'b01);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
